// File: rtl/da_feeder_pkg.sv
// rtl/da_feeder_pkg.sv - shared constants and state encoding for the DA bit-slice feeder
package da_feeder_pkg;

    localparam int NTAPS         = 64;
    localparam int BANKS         = 8;
    localparam int TAPS_PER_BANK = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_SLICE = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

endpackage

// File: rtl/da_slice_mux.sv
// rtl/da_slice_mux.sv - gathers bit bit_sel of all 64 taps into eight 8-bit DA addresses
module da_slice_mux
    import da_feeder_pkg::*;
#(
    parameter int SAMPLE_W = 16
) (
    input  logic [SAMPLE_W-1:0]         taps    [NTAPS],
    input  logic [$clog2(SAMPLE_W)-1:0] bit_sel,
    output logic [TAPS_PER_BANK-1:0]    addr    [BANKS]
);

    // Bank k, bit j addresses tap 8k+j.
    always_comb begin
        for (int k = 0; k < BANKS; k++) begin
            for (int j = 0; j < TAPS_PER_BANK; j++) begin
                addr[k][j] = taps[k*TAPS_PER_BANK + j][bit_sel];
            end
        end
    end

endmodule

// File: rtl/da_feeder.sv
// rtl/da_feeder.sv - 64-tap delay line feeding MSB-first bit slices to a distributed-arithmetic core
module da_feeder
    import da_feeder_pkg::*;
#(
    parameter int SAMPLE_W = 16,
    parameter int NTAPS    = da_feeder_pkg::NTAPS
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic [SAMPLE_W-1:0] sample_in,
    input  logic                sample_valid,
    output logic                sample_ready,
    input  logic                flush,
    output logic [7:0]          A7,
    output logic [7:0]          A6,
    output logic [7:0]          A5,
    output logic [7:0]          A4,
    output logic [7:0]          A3,
    output logic [7:0]          A2,
    output logic [7:0]          A1,
    output logic [7:0]          A0,
    output logic                start,
    output logic                valid_in,
    input  logic                slice_ack,
    input  logic                result_valid,
    output logic                busy
);

    localparam int BW = $clog2(SAMPLE_W);

    state_t                    state_q, state_d;
    logic [BW-1:0]             bit_q;
    logic [SAMPLE_W-1:0]       taps_q   [NTAPS];
    logic [TAPS_PER_BANK-1:0]  a_q      [BANKS];
    logic [TAPS_PER_BANK-1:0]  mux_addr [BANKS];
    logic [BW-1:0]             mux_sel;
    logic                      accept, clear, load_first, advance, finish;

    always_comb begin
        state_d    = state_q;
        accept     = 1'b0;
        clear      = 1'b0;
        load_first = 1'b0;
        advance    = 1'b0;
        finish     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (flush) begin
                    clear = 1'b1;
                end else if (sample_valid) begin
                    accept  = 1'b1;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                load_first = 1'b1;
                state_d    = ST_SLICE;
            end
            ST_SLICE: begin
                if (slice_ack) begin
                    if (bit_q != '0) begin
                        advance = 1'b1;
                    end else begin
                        finish  = 1'b1;
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (result_valid) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // The mux looks one slice ahead so the address registers load in step with the bit counter.
    assign mux_sel = load_first ? BW'(SAMPLE_W - 1) : (bit_q - BW'(1));

    da_slice_mux #(.SAMPLE_W(SAMPLE_W)) u_slice_mux (
        .taps    (taps_q),
        .bit_sel (mux_sel),
        .addr    (mux_addr)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < NTAPS; i++) taps_q[i] <= '0;
        end else if (clear) begin
            for (int i = 0; i < NTAPS; i++) taps_q[i] <= '0;
        end else if (accept) begin
            taps_q[0] <= sample_in;
            for (int i = 1; i < NTAPS; i++) taps_q[i] <= taps_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            bit_q <= '0;
            for (int k = 0; k < BANKS; k++) a_q[k] <= '0;
        end else if (load_first) begin
            bit_q <= BW'(SAMPLE_W - 1);
            for (int k = 0; k < BANKS; k++) a_q[k] <= mux_addr[k];
        end else if (advance) begin
            bit_q <= bit_q - BW'(1);
            for (int k = 0; k < BANKS; k++) a_q[k] <= mux_addr[k];
        end else if (finish) begin
            for (int k = 0; k < BANKS; k++) a_q[k] <= '0;
        end
    end

    assign sample_ready = (state_q == ST_IDLE) && !flush;
    assign start        = (state_q == ST_START);
    assign valid_in     = (state_q == ST_SLICE);
    assign busy         = (state_q != ST_IDLE);

    assign A0 = a_q[0];
    assign A1 = a_q[1];
    assign A2 = a_q[2];
    assign A3 = a_q[3];
    assign A4 = a_q[4];
    assign A5 = a_q[5];
    assign A6 = a_q[6];
    assign A7 = a_q[7];

endmodule

// File: tb/tb_da_feeder.sv
// tb/tb_da_feeder.sv - randomized scoreboard bench for da_feeder
module tb_da_feeder;

    localparam int SW = 16;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic [SW-1:0] sample_in = '0;
    logic          sample_valid = 1'b0;
    logic          sample_ready;
    logic          flush = 1'b0;
    logic [7:0]    A7, A6, A5, A4, A3, A2, A1, A0;
    logic          start, valid_in, busy;
    logic          slice_ack = 1'b0;
    logic          result_valid = 1'b0;

    always #5 clk = ~clk;

    da_feeder #(.SAMPLE_W(SW)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .flush        (flush),
        .A7           (A7),
        .A6           (A6),
        .A5           (A5),
        .A4           (A4),
        .A3           (A3),
        .A2           (A2),
        .A1           (A1),
        .A0           (A0),
        .start        (start),
        .valid_in     (valid_in),
        .slice_ack    (slice_ack),
        .result_valid (result_valid),
        .busy         (busy)
    );

    wire [63:0] a_all = {A7, A6, A5, A4, A3, A2, A1, A0};

    int total = 0;
    int bad   = 0;

    // Reference: delay line as a plain array, one 64-bit slice word per bit plane.
    logic [SW-1:0] m_taps [64] = '{default: '0};
    logic [63:0]   exp_q [$];
    int            phase = 0;        // 0 idle, 1 start cycle, 2 slicing, 3 awaiting result
    int            slices_left = 0;
    int            accepts = 0;
    int            seen = 0;
    logic [63:0]   first_seen = '0;
    logic [63:0]   last_seen = '0;
    int            ack_mode = 0;
    int            rv_mode = 0;
    int            hold_cnt = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    initial forever begin
        logic [63:0] s;
        @(posedge clk or negedge resetn);
        if (!resetn) begin
            phase = 0;
            slices_left = 0;
            exp_q.delete();
            for (int i = 0; i < 64; i++) m_taps[i] = '0;
        end else begin
            case (phase)
                0: if (flush) begin
                       for (int i = 0; i < 64; i++) m_taps[i] = '0;
                   end else if (sample_valid) begin
                       for (int i = 63; i > 0; i--) m_taps[i] = m_taps[i-1];
                       m_taps[0] = sample_in;
                       for (int b = SW - 1; b >= 0; b--) begin
                           for (int i = 0; i < 64; i++) s[i] = m_taps[i][b];
                           exp_q.push_back(s);
                       end
                       seen = 0;
                       accepts++;
                       phase = 1;
                   end
                1: begin
                       phase = 2;
                       slices_left = SW;
                   end
                2: if (slice_ack) begin
                       slices_left--;
                       if (slices_left == 0) begin
                           phase = 3;
                           chk("slices_issued", 64'(seen), 64'(SW));
                       end
                   end
                default: if (result_valid) phase = 0;
            endcase
        end
    end

    initial forever begin
        @(negedge clk);
        if (resetn) begin
            chk("sample_ready", sample_ready, (phase == 0) && !flush);
            chk("start", start, phase == 1);
            chk("valid_in", valid_in, phase == 2);
            chk("busy", busy, phase != 0);
            if (phase == 2) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL slice_extra actual=%h required=none", a_all);
                end else begin
                    chk("slice", a_all, exp_q[0]);
                    if (slice_ack) begin
                        if (seen == 0) first_seen = a_all;
                        last_seen = a_all;
                        seen++;
                        void'(exp_q.pop_front());
                    end
                end
            end else begin
                chk("a_quiet", a_all, 64'h0);
            end
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        case (ack_mode)
            0: slice_ack = 1'b1;
            1: slice_ack = ($urandom % 4) != 0;
            default: begin
                if (phase == 2 && slices_left == 8 && hold_cnt < 5) begin
                    slice_ack = 1'b0;
                    hold_cnt++;
                end else begin
                    slice_ack = 1'b1;
                end
            end
        endcase
        result_valid = (rv_mode == 0) ? 1'b1 : (($urandom % 2) == 0);
    end

    task automatic send(input logic [SW-1:0] v);
        int n0;
        int guard;
        n0 = accepts;
        guard = 0;
        @(posedge clk);
        #1;
        sample_in = v;
        sample_valid = 1'b1;
        do begin
            @(posedge clk);
            #1;
            guard++;
        end while (accepts == n0 && guard < 300);
        sample_valid = 1'b0;
        if (accepts == n0) begin
            total++;
            bad++;
            $display("FAIL send_timeout actual=no_accept required=accept");
        end
    endtask

    task automatic wait_idle();
        int guard;
        guard = 0;
        while (phase != 0 && guard < 500) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (phase != 0) begin
            total++;
            bad++;
            $display("FAIL idle_timeout actual=phase%0d required=idle", phase);
        end
    endtask

    task automatic pulse_flush(input logic with_valid);
        @(posedge clk);
        #1;
        flush = 1'b1;
        sample_valid = with_valid;
        sample_in = 16'hFFFF;
        @(posedge clk);
        #1;
        flush = 1'b0;
        sample_valid = 1'b0;
    endtask

    initial begin
        int guard;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_a", a_all, 64'h0);
        chk("rst_start", start, 1'b0);
        chk("rst_valid_in", valid_in, 1'b0);
        chk("rst_busy", busy, 1'b0);
        resetn = 1'b1;

        // Single impulse, ack tied high.
        send(16'h0001);
        wait_idle();
        chk("impulse_first", first_seen, 64'h0);
        chk("impulse_last", last_seen, 64'h1);

        // Fill every tap with the sign bit.
        pulse_flush(1'b0);
        for (int i = 0; i < 65; i++) send(16'h8000);
        wait_idle();
        chk("sign_first", first_seen, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("sign_last", last_seen, 64'h0);

        // sample_valid held high across a computation.
        rv_mode = 1;
        @(posedge clk);
        #1;
        sample_in = 16'h1234;
        sample_valid = 1'b1;
        guard = 0;
        while (accepts < 67 + 1 && guard < 400) begin
            @(posedge clk);
            #1;
            if (accepts == 67) sample_in = 16'h00F0;
            guard++;
        end
        sample_valid = 1'b0;
        chk("held_valid_accepts", 64'(accepts), 64'd68);
        wait_idle();

        // Ack withheld for five cycles on bit 7.
        ack_mode = 2;
        hold_cnt = 0;
        send(SW'($urandom));
        wait_idle();
        chk("ack_hold_cycles", 64'(hold_cnt), 64'd5);
        ack_mode = 0;

        // Flush wins over a simultaneous sample.
        pulse_flush(1'b1);
        send(16'h0001);
        wait_idle();
        chk("flush_first", first_seen, 64'h0);
        chk("flush_last", last_seen, 64'h1);

        // Reset while bit 9 is on the bus.
        ack_mode = 1;
        send(SW'($urandom) | 16'h0200);
        guard = 0;
        while (!(phase == 2 && slices_left == 10) && guard < 300) begin
            @(posedge clk);
            #1;
            guard++;
        end
        chk("reached_b9", 64'(slices_left), 64'd10);
        #2;
        resetn = 1'b0;
        #1;
        chk("async_a", a_all, 64'h0);
        chk("async_valid_in", valid_in, 1'b0);
        chk("async_busy", busy, 1'b0);
        chk("async_start", start, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
        repeat (6) @(posedge clk);
        send(16'h0001);
        wait_idle();
        chk("post_reset_last", last_seen, 64'h1);

        // Random traffic with random handshakes and occasional flushes.
        rv_mode = 1;
        for (int n = 0; n < 40; n++) begin
            if (($urandom % 6) == 0) pulse_flush($urandom % 2 == 1);
            send(SW'($urandom));
        end
        wait_idle();
        repeat (3) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
